// File: rtl/fila_parametrizada_if.sv
// Bundle of request and status signals for the parametrised queue.
// No logic inside, so it adds no latency.
// The slave modport (the queue) has no backpressure; the master reads full/empty to pace itself.
interface fila_parametrizada_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic             clear_in;
    logic             enqueue_in;
    logic [WIDTH-1:0] data_in;
    logic             dequeue_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid_out;
    logic [LEN_W-1:0] len_out;
    logic             full_out;
    logic             empty_out;
    logic             almost_full_out;
    logic             almost_empty_out;
    logic             overflow_out;
    logic             underflow_out;

    modport master (
        output clear_in, enqueue_in, data_in, dequeue_in,
        input  data_out, data_valid_out, len_out, full_out, empty_out,
               almost_full_out, almost_empty_out, overflow_out, underflow_out
    );

    modport slave (
        input  clear_in, enqueue_in, data_in, dequeue_in,
        output data_out, data_valid_out, len_out, full_out, empty_out,
               almost_full_out, almost_empty_out, overflow_out, underflow_out
    );
endinterface

// File: rtl/fila_parametrizada.sv
// Circular-buffer queue with configurable width and depth, FIFO or LIFO order, flush and sticky error flags.
// Latency: a dequeued word is on data_out one cycle after the request, with data_valid_out high in that cycle.
// No backpressure: a request that cannot be served is dropped and recorded in overflow_out or underflow_out.
module fila_parametrizada #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int LIFO_MODE = 0,
    parameter int AF_LEVEL  = 6,
    parameter int AE_LEVEL  = 1,
    parameter int LEN_W     = $clog2(DEPTH + 1)
) (
    input  logic               clock_10khz,
    input  logic               reset_n,
    fila_parametrizada_if.slave q_if
);
    localparam int  PTR_W   = $clog2(DEPTH);
    localparam bit  IS_LIFO = (LIFO_MODE != 0);

    // Storage is never reset; reads are gated by the count, so stale words cannot escape.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvld_q, dvld_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full, empty;
    logic             deq_ok, enq_ok, bypass, mem_we;
    logic [PTR_W-1:0] wr_addr, rd_addr;

    // Explicit wrap so that non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (len_q == LEN_W'(DEPTH));
    assign empty  = (len_q == '0);
    assign deq_ok = q_if.dequeue_in & ~empty;
    // FIFO may accept a write when full as long as a read frees a slot in the same cycle.
    assign enq_ok = q_if.enqueue_in & (~full | (deq_ok & ~IS_LIFO));
    // LIFO push+pop together hands the incoming word straight back out.
    assign bypass = IS_LIFO & enq_ok & deq_ok;

    // In LIFO order the count doubles as the top-of-stack pointer.
    assign wr_addr = IS_LIFO ? PTR_W'(len_q) : wr_ptr_q;
    assign rd_addr = IS_LIFO ? PTR_W'(len_q - 1'b1) : rd_ptr_q;

    // Next-state: flush first, then error capture, bypass, or normal read/write.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        dout_d   = dout_q;
        dvld_d   = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        mem_we   = 1'b0;
        if (q_if.clear_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            len_d    = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (q_if.enqueue_in && !enq_ok) begin
                ovf_d = 1'b1;
            end
            if (q_if.dequeue_in && !deq_ok) begin
                unf_d = 1'b1;
            end
            if (bypass) begin
                dout_d = q_if.data_in;
                dvld_d = 1'b1;
            end else begin
                if (deq_ok) begin
                    dout_d   = mem_q[rd_addr];
                    dvld_d   = 1'b1;
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end
                if (enq_ok) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                end
                if (enq_ok && !deq_ok) begin
                    len_d = len_q + 1'b1;
                end else if (deq_ok && !enq_ok) begin
                    len_d = len_q - 1'b1;
                end
            end
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clock_10khz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            dout_q   <= '0;
            dvld_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            dout_q   <= dout_d;
            dvld_q   <= dvld_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Memory write port; no reset on the array.
    always_ff @(posedge clock_10khz) begin
        if (mem_we) begin
            mem_q[wr_addr] <= q_if.data_in;
        end
    end

    assign q_if.data_out         = dout_q;
    assign q_if.data_valid_out   = dvld_q;
    assign q_if.len_out          = len_q;
    assign q_if.full_out         = full;
    assign q_if.empty_out        = empty;
    assign q_if.almost_full_out  = (len_q >= LEN_W'(AF_LEVEL));
    assign q_if.almost_empty_out = (len_q <= LEN_W'(AE_LEVEL));
    assign q_if.overflow_out     = ovf_q;
    assign q_if.underflow_out    = unf_q;
endmodule

// File: tb/tb_fila_parametrizada.sv
// Bench for fila_parametrizada: one FIFO and one LIFO instance against a queue model with a scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are checked there and at the falling edge.
// The model applies the same accept/reject rules, so dropped requests are predicted, not observed.
module tb_fila_parametrizada;
    localparam int DEPTH = 8;

    logic clk;
    logic reset_n;

    fila_parametrizada_if #(.WIDTH(8), .DEPTH(DEPTH)) f_if ();
    fila_parametrizada_if #(.WIDTH(8), .DEPTH(DEPTH)) l_if ();

    fila_parametrizada #(.WIDTH(8), .DEPTH(DEPTH), .LIFO_MODE(0)) u_fifo (
        .clock_10khz (clk),
        .reset_n     (reset_n),
        .q_if        (f_if)
    );

    fila_parametrizada #(.WIDTH(8), .DEPTH(DEPTH), .LIFO_MODE(1)) u_lifo (
        .clock_10khz (clk),
        .reset_n     (reset_n),
        .q_if        (l_if)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state per instance: index 0 = FIFO, 1 = LIFO.
    logic [7:0] f_mdl [$];
    logic [7:0] l_mdl [$];
    logic [7:0] f_exp [$];
    logic [7:0] l_exp [$];
    bit         ovf_e  [2];
    bit         unf_e  [2];
    bit         vld_e  [2];
    logic [7:0] dout_e [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        f_mdl.delete();
        l_mdl.delete();
        f_exp.delete();
        l_exp.delete();
        for (int i = 0; i < 2; i++) begin
            ovf_e[i]  = 1'b0;
            unf_e[i]  = 1'b0;
            vld_e[i]  = 1'b0;
            dout_e[i] = 8'h00;
        end
    endtask

    task automatic chk_state(input bit lifo, input string tag);
        int sz;
        logic [3:0] len;
        logic full, empty, af, ae, ovf, unf, vld;
        logic [7:0] dout;
        sz = lifo ? l_mdl.size() : f_mdl.size();
        if (lifo) begin
            len = l_if.len_out; full = l_if.full_out; empty = l_if.empty_out;
            af = l_if.almost_full_out; ae = l_if.almost_empty_out;
            ovf = l_if.overflow_out; unf = l_if.underflow_out;
            vld = l_if.data_valid_out; dout = l_if.data_out;
        end else begin
            len = f_if.len_out; full = f_if.full_out; empty = f_if.empty_out;
            af = f_if.almost_full_out; ae = f_if.almost_empty_out;
            ovf = f_if.overflow_out; unf = f_if.underflow_out;
            vld = f_if.data_valid_out; dout = f_if.data_out;
        end
        check({tag, "_len"},   32'(len),   32'(sz));
        check({tag, "_full"},  32'(full),  32'(sz == DEPTH));
        check({tag, "_empty"}, 32'(empty), 32'(sz == 0));
        check({tag, "_af"},    32'(af),    32'(sz >= 6));
        check({tag, "_ae"},    32'(ae),    32'(sz <= 1));
        check({tag, "_ovf"},   32'(ovf),   32'(ovf_e[lifo]));
        check({tag, "_unf"},   32'(unf),   32'(unf_e[lifo]));
        check({tag, "_vld"},   32'(vld),   32'(vld_e[lifo]));
        check({tag, "_dout"},  32'(dout),  32'(dout_e[lifo]));
    endtask

    // One clock of stimulus on one instance, with the model stepped alongside.
    task automatic cyc(input bit lifo, input string tag, input bit clr,
                       input bit enq, input logic [7:0] d, input bit deq);
        int sz;
        bit dok, eok;
        logic [7:0] w;
        sz = lifo ? l_mdl.size() : f_mdl.size();
        w  = 8'h00;
        if (lifo) begin
            l_if.clear_in = clr; l_if.enqueue_in = enq; l_if.data_in = d; l_if.dequeue_in = deq;
        end else begin
            f_if.clear_in = clr; f_if.enqueue_in = enq; f_if.data_in = d; f_if.dequeue_in = deq;
        end
        vld_e[lifo] = 1'b0;
        if (clr) begin
            if (lifo) l_mdl.delete(); else f_mdl.delete();
            ovf_e[lifo] = 1'b0;
            unf_e[lifo] = 1'b0;
        end else begin
            dok = deq && (sz > 0);
            eok = enq && ((sz < DEPTH) || (dok && !lifo));
            if (enq && !eok) ovf_e[lifo] = 1'b1;
            if (deq && !dok) unf_e[lifo] = 1'b1;
            if (lifo) begin
                if (dok && eok) begin
                    w = d;
                end else begin
                    if (dok) begin
                        w = l_mdl[$];
                        void'(l_mdl.pop_back());
                    end
                    if (eok) l_mdl.push_back(d);
                end
            end else begin
                if (dok) w = f_mdl.pop_front();
                if (eok) f_mdl.push_back(d);
            end
            if (dok) begin
                if (lifo) l_exp.push_back(w); else f_exp.push_back(w);
                dout_e[lifo] = w;
                vld_e[lifo]  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (lifo) begin
            l_if.clear_in = 1'b0; l_if.enqueue_in = 1'b0; l_if.dequeue_in = 1'b0;
        end else begin
            f_if.clear_in = 1'b0; f_if.enqueue_in = 1'b0; f_if.dequeue_in = 1'b0;
        end
        chk_state(lifo, tag);
    endtask

    // Scoreboard: every valid strobe must match the oldest predicted word.
    always @(negedge clk) begin
        if (reset_n && f_if.data_valid_out) begin
            if (f_exp.size() > 0) check("f_sb_data", 32'(f_if.data_out), 32'(f_exp.pop_front()));
            else                  check("f_sb_spurious_vld", 32'(f_if.data_valid_out), 32'd0);
        end
        if (reset_n && l_if.data_valid_out) begin
            if (l_exp.size() > 0) check("l_sb_data", 32'(l_if.data_out), 32'(l_exp.pop_front()));
            else                  check("l_sb_spurious_vld", 32'(l_if.data_valid_out), 32'd0);
        end
    end

    initial begin
        f_if.clear_in = 1'b0; f_if.enqueue_in = 1'b0; f_if.data_in = 8'h00; f_if.dequeue_in = 1'b0;
        l_if.clear_in = 1'b0; l_if.enqueue_in = 1'b0; l_if.data_in = 8'h00; l_if.dequeue_in = 1'b0;
        model_reset();
        reset_n = 1'b0;
        #230;
        chk_state(0, "rst_f");
        chk_state(1, "rst_l");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // FIFO basic order
        cyc(0, "t1_enq", 0, 1, 8'h11, 0);
        cyc(0, "t1_enq", 0, 1, 8'h22, 0);
        cyc(0, "t1_enq", 0, 1, 8'h33, 0);
        for (int i = 0; i < 3; i++) cyc(0, "t1_deq", 0, 0, 8'h00, 1);
        cyc(0, "t1_idle", 0, 0, 8'h00, 0);

        // FIFO fill, overflow, wrap
        for (int i = 0; i < 8; i++) cyc(0, "t2_fill", 0, 1, 8'h40 + 8'(i), 0);
        cyc(0, "t2_ovf", 0, 1, 8'hFF, 0);
        for (int i = 0; i < 5; i++) cyc(0, "t2_deq", 0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) cyc(0, "t2_enq", 0, 1, 8'h80 + 8'(i), 0);

        // FIFO full pass-through
        cyc(0, "t3_both_full", 0, 1, 8'hA5, 1);
        for (int i = 0; i < 8; i++) cyc(0, "t3_drain", 0, 0, 8'h00, 1);

        // Empty underflow, clear, ignored requests under clear
        cyc(0, "t5_unf", 0, 0, 8'h00, 1);
        cyc(0, "t5_clr", 1, 0, 8'h00, 0);
        cyc(0, "t5_both_empty", 0, 1, 8'h5A, 1);
        cyc(0, "t5_clr_busy", 1, 1, 8'h66, 1);
        cyc(0, "t5_idle", 0, 0, 8'h00, 0);

        // LIFO order, bypass, full
        cyc(1, "t4_push", 0, 1, 8'h01, 0);
        cyc(1, "t4_push", 0, 1, 8'h02, 0);
        cyc(1, "t4_push", 0, 1, 8'h03, 0);
        for (int i = 0; i < 3; i++) cyc(1, "t4_pop", 0, 0, 8'h00, 1);
        cyc(1, "t4_push1", 0, 1, 8'h05, 0);
        cyc(1, "t4_bypass", 0, 1, 8'h7E, 1);
        cyc(1, "t4_pop_last", 0, 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) cyc(1, "t4_fill", 0, 1, 8'hC0 + 8'(i), 0);
        cyc(1, "t4_full_both", 0, 1, 8'hEE, 1);
        cyc(1, "t4_pop", 0, 0, 8'h00, 1);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) cyc(0, "t6_fill", 0, 1, 8'h90 + 8'(i), 0);
        #20;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_state(0, "t6_rst_f");
        chk_state(1, "t6_rst_l");
        #10;
        reset_n = 1'b1;
        cyc(0, "t6_unf", 0, 0, 8'h00, 1);
        cyc(0, "t6_idle", 0, 0, 8'h00, 0);

        @(negedge clk);
        #1;
        check("f_sb_drained", 32'(f_exp.size()), 32'd0);
        check("l_sb_drained", 32'(l_exp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
